adc_sample_capture: RTL and testbench



---
 rtl/audio_rec_pkg.sv | 15 +
 rtl/adc_sclk_gen.sv | 52 +++++
 rtl/adc_sample_capture.sv | 182 ++++++++++++++++++
 tb/tb_adc_sample_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_rec_pkg.sv
// Shared types and constants for the audio recorder capture path.
package audio_rec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    QUIET   = 2'd2,
    READY   = 2'd3
  } state_t;

  // ADC frame: 16 SCLK cycles, 4 leading zeros, then data MSB first.
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_ZEROS = 4;

endpackage

// File: rtl/adc_sclk_gen.sv
// ADC serial clock generator: toggles SCLK every CLK_DIV clocks while enabled,
// starting with a fall; idles high. Rise/fall strobes are asserted on the
// clock whose edge produces the corresponding SCLK transition.
module adc_sclk_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  // Half-period counting and next SCLK level; strobes flag the coming edge.
  always_comb begin
    wrap   = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
    sclk_rise = en && wrap && !sclk_q;
    sclk_fall = en && wrap && sclk_q;
  end

  // Register the counter and the SCLK output.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/adc_sample_capture.sv
// ADC sample capture: paces serial ADC conversions from a sample tick,
// deserialises each 16-bit frame and presents a 12-bit sample with a
// DataReady pulse. Optional feature macro ADC_AVG4_EN: average four frames
// per presented sample.
module adc_sample_capture
  import audio_rec_pkg::*;
#(
  parameter int CLK_DIV      = 5,
  parameter int SAMPLE_DIV   = 2268,
  parameter int DATA_WIDTH   = 12,
  parameter int READY_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  AdcSdata,
  output logic                  AdcSclk,
  output logic                  AdcCSn,
  output logic [DATA_WIDTH-1:0] Sample,
  output logic                  DataReady,
  output logic                  Busy,
  output logic                  Overrun
);

  localparam int TW  = $clog2(SAMPLE_DIV);
  localparam int PW  = (CLK_DIV > READY_CYCLES) ? CLK_DIV : READY_CYCLES;
  localparam int PCW = $clog2(PW + 1);

  state_t                    state_q, state_d;
  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [PCW-1:0]            phase_cnt_q, phase_cnt_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0]     sample_q, sample_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      csn_q, csn_d;
  logic                      overrun_q, overrun_d;
  logic                      tick;
  logic                      sclk_rise, sclk_fall;
`ifdef ADC_AVG4_EN
  logic [13:0]               acc_q, acc_d;
  logic [1:0]                avg_phase_q, avg_phase_d;
  logic [13:0]               avg_sum;
`endif

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (Clock),
    .srst      (Reset),
    .en        (state_q == CONVERT),
    .sclk      (AdcSclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // Tick pacing, frame sequencing and next values of all registered outputs.
  always_comb begin
    tick        = Enable && (tick_cnt_q == TW'(SAMPLE_DIV - 1));
    tick_cnt_d  = (!Enable || tick) ? '0 : tick_cnt_q + 1'b1;
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sample_d    = sample_q;
    overrun_d   = overrun_q;
`ifdef ADC_AVG4_EN
    acc_d       = acc_q;
    avg_phase_d = avg_phase_q;
    avg_sum     = acc_q + 14'(shift_q[DATA_WIDTH-1:0]);
`endif

    // A tick that finds a frame in flight is dropped and flagged.
    if (!Enable) overrun_d = 1'b0;
    else if (tick && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d   = CONVERT;
          bit_cnt_d = '0;
        end
      end
      CONVERT: begin
        // bit_cnt counts bits presented (SCLK falls); the rise after the
        // last fall captures the final bit and ends the frame.
        if (sclk_fall) bit_cnt_d = bit_cnt_q + 1'b1;
        if (sclk_rise) begin
          shift_d = {shift_q[ADC_FRAME_BITS-2:0], AdcSdata};
          if (bit_cnt_q == 5'(ADC_FRAME_BITS)) begin
            state_d     = QUIET;
            phase_cnt_d = '0;
          end
        end
      end
      QUIET: begin
        if (phase_cnt_q == PCW'(CLK_DIV - 1)) begin
          phase_cnt_d = '0;
`ifdef ADC_AVG4_EN
          if (avg_phase_q == 2'd3) begin
            state_d     = READY;
            sample_d    = DATA_WIDTH'(avg_sum >> 2);
            acc_d       = '0;
            avg_phase_d = '0;
          end else begin
            state_d     = IDLE;
            acc_d       = avg_sum;
            avg_phase_d = avg_phase_q + 1'b1;
          end
`else
          state_d  = READY;
          sample_d = shift_q[DATA_WIDTH-1:0];
`endif
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      READY: begin
        if (phase_cnt_q == PCW'(READY_CYCLES - 1)) begin
          state_d     = IDLE;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ADC_AVG4_EN
    // Averaging restarts from frame one whenever capture is disabled.
    if (!Enable) begin
      acc_d       = '0;
      avg_phase_d = '0;
    end
`endif

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == READY);
    csn_d   = (state_d != CONVERT);
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      phase_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sample_q    <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      csn_q       <= 1'b1;
      overrun_q   <= 1'b0;
`ifdef ADC_AVG4_EN
      acc_q       <= '0;
      avg_phase_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      csn_q       <= csn_d;
      overrun_q   <= overrun_d;
`ifdef ADC_AVG4_EN
      acc_q       <= acc_d;
      avg_phase_q <= avg_phase_d;
`endif
    end
  end

  assign AdcCSn    = csn_q;
  assign Sample    = sample_q;
  assign DataReady = ready_q;
  assign Busy      = busy_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Testbench for adc_sample_capture: directed sequence with random ADC words,
// expectations derived from the frame timing formulas.
module tb_adc_sample_capture;

  localparam int CD = 2;
  localparam int SD = 100;
  localparam int RC = 4;
  localparam int SD_OV = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sdata = 1'b0;
  logic        sclk, csn, dr, busy, ovr;
  logic [11:0] sample;

  logic        ov_en = 1'b0;
  logic        ov_sdata = 1'b0;
  logic        ov_sclk, ov_csn, ov_dr, ov_busy, ov_ovr;
  logic [11:0] ov_sample;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] adc_word = 16'h0;
  logic [15:0] ov_word = 16'h0;
  int          idx = 15;
  int          ov_idx = 15;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_capture #(.CLK_DIV(CD), .SAMPLE_DIV(SD), .DATA_WIDTH(12), .READY_CYCLES(RC)) dut (
    .Clock(clk), .Reset(rst), .Enable(en), .AdcSdata(sdata),
    .AdcSclk(sclk), .AdcCSn(csn), .Sample(sample), .DataReady(dr),
    .Busy(busy), .Overrun(ovr)
  );

  adc_sample_capture #(.CLK_DIV(CD), .SAMPLE_DIV(SD_OV), .DATA_WIDTH(12), .READY_CYCLES(RC)) dut_ov (
    .Clock(clk), .Reset(rst), .Enable(ov_en), .AdcSdata(ov_sdata),
    .AdcSclk(ov_sclk), .AdcCSn(ov_csn), .Sample(ov_sample), .DataReady(ov_dr),
    .Busy(ov_busy), .Overrun(ov_ovr)
  );

  // ADC models: present the next frame bit (MSB first) on each SCLK fall.
  always @(negedge sclk or posedge csn) begin
    if (csn) idx = 15;
    else begin
      sdata = adc_word[idx];
      if (idx > 0) idx = idx - 1;
    end
  end

  always @(negedge ov_sclk or posedge ov_csn) begin
    if (ov_csn) ov_idx = 15;
    else begin
      ov_sdata = ov_word[ov_idx];
      if (ov_idx > 0) ov_idx = ov_idx - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for chip select to fall and check when it happened.
  task automatic wait_fall(input int exp_cyc, input string tag);
    int k;
    k = 0;
    while (csn !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, cyc, exp_cyc);
  endtask

  // Follow one frame from the chip-select fall to the end of DataReady.
  task automatic finish_frame(input logic [15:0] word, input int drop_at);
    int   n_low, rises, off, w;
    logic prev;
    bit   busy_ok, stable_ok;
    n_low = 0; rises = 0; w = 0; busy_ok = 1'b1; stable_ok = 1'b1;
    prev = sclk;
    while (csn === 1'b0 && n_low < 200) begin
      if (n_low == drop_at) en = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n_low++;
      if (prev === 1'b0 && sclk === 1'b1) rises++;
      prev = sclk;
    end
    chk("csn_low_clocks", n_low, 32 * CD);
    chk("sclk_rises", rises, 16);
    off = n_low;
    while (dr !== 1'b1 && off < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      off++;
    end
    chk("dr_rise_offset", off, 33 * CD);
    chk("sample", sample, word[11:0]);
    while (dr === 1'b1 && w < 50) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (sample !== word[11:0]) stable_ok = 1'b0;
      @(negedge clk);
      w++;
    end
    chk("dr_width", w, RC);
    chk("busy_in_frame", busy_ok, 1);
    chk("sample_stable_in_dr", stable_ok, 1);
    chk("sample_after_dr", sample, word[11:0]);
    chk("busy_after_frame", busy, 0);
    $display("frame word=%h sample=%h csn_low=%0d rises=%0d dr_off=%0d dr_w=%0d", word, sample, n_low, rises, off, w);
  endtask

  initial begin
    int          e0, e1, eo, act, k, nrise, rise_cyc;
    logic [15:0] w;
    logic [11:0] rise_sample;
    logic        prev_dr;

    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 1);
    chk("rst_csn", csn, 1);
    chk("rst_sample", sample, 0);
    chk("rst_dr", dr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", ovr, 0);
    rst = 1'b0;
    en = 1'b1;
    e0 = cyc;

`ifdef ADC_AVG4_EN
    nrise = 0; rise_cyc = 0; rise_sample = 12'h0; prev_dr = 1'b0;
    for (int f = 0; f < 4; f++) begin
      adc_word = {4'($urandom_range(15, 0)), 12'((f + 1) * 256)};
      wait_fall(e0 + SD * (f + 1), "avg_csn_fall");
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (dr === 1'b1 && prev_dr !== 1'b1) begin
          nrise++;
          rise_cyc = cyc;
          rise_sample = sample;
        end
        prev_dr = dr;
      end
      $display("avg frame %0d word=%h dr_pulses_so_far=%0d", f, adc_word, nrise);
    end
    chk("avg_dr_pulses", nrise, 1);
    chk("avg_sample", rise_sample, 12'h280);
    chk("avg_dr_cycle", rise_cyc, e0 + 4 * SD + 33 * CD);
`else
    // Back-to-back frames; the first uses the reference word 0x0A5C.
    for (int f = 0; f < 5; f++) begin
      if (f == 0) w = 16'h0A5C;
      else if (f == 1) w = {4'($urandom_range(15, 0)), 12'hFFF};
      else if (f == 2) w = {4'($urandom_range(15, 0)), 12'h001};
      else w = 16'($urandom);
      adc_word = w;
      wait_fall(e0 + SD * (f + 1), "csn_fall_cycle");
      finish_frame(w, -1);
    end
    chk("no_overrun_b2b", ovr, 0);

    // Reset at frame clock 20.
    adc_word = 16'($urandom);
    wait_fall(e0 + SD * 6, "csn_fall_pre_reset");
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_csn", csn, 1);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_dr", dr, 0);
    chk("midrst_sample", sample, 0);
    chk("midrst_busy", busy, 0);
    $display("reset mid-frame at clock 20: csn=%b sclk=%b sample=%h", csn, sclk, sample);
    rst = 1'b0;
    e1 = cyc;

    // Enable dropped at frame clock 10.
    w = 16'($urandom);
    adc_word = w;
    wait_fall(e1 + SD, "csn_fall_post_reset");
    finish_frame(w, 10);
    act = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (csn !== 1'b1) act++;
    end
    chk("no_csn_after_disable", act, 0);
    $display("enable dropped: csn activity after frame=%0d", act);
`endif

    // Overrun instance: tick period shorter than a frame.
    ov_word = 16'($urandom);
    ov_en = 1'b1;
    eo = cyc;
    repeat (SD_OV * 2 - 1) @(negedge clk);
    chk("ov_before_2nd_tick", ov_ovr, 0);
    @(negedge clk);
    chk("ov_after_2nd_tick", ov_ovr, 1);
`ifndef ADC_AVG4_EN
    k = cyc - eo;
    while (ov_dr !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("ov_dr_cycle", k, SD_OV + 33 * CD);
    chk("ov_sample", ov_sample, ov_word[11:0]);
`endif
    ov_en = 1'b0;
    @(negedge clk);
    chk("ov_cleared_by_disable", ov_ovr, 0);
    $display("overrun word=%h sample=%h overrun=%b", ov_word, ov_sample, ov_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
